// File: rtl/timber_rom_loader.sv
// Timber ROM loader: buffers hps_io ioctl bytes in a small FIFO and routes them by region
// to SDRAM port1/port2 (toggle handshakes) or the BG dl_* bus. Option: ROM_LOADER_CHECKSUM_EN.
module timber_rom_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] SP_BASE    = 25'h11000,
  parameter logic [24:0] BG_BASE    = 25'h31000,
  parameter logic [24:0] ROM_END    = 25'h39000,
  parameter logic [15:0] RST_HOLD   = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [17:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic [15:0] dl_addr,
  output logic        dl_wr,
  output logic [7:0]  dl_data,
  output logic        busy,
  output logic        overflow,
  output logic        rom_loaded,
`ifdef ROM_LOADER_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic        core_reset
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT1, S_WAIT2, S_BG} state_t;

  state_t      state_reg;
  logic        wr_sync_reg, wr_prev_reg;
  logic        dnld_sync_reg, dnld_prev_reg;
  logic [24:0] addr_sync_reg;
  logic [7:0]  data_sync_reg;
  logic        loading_reg;
  logic [15:0] hold_cnt_reg;

  logic [32:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr_reg, rd_ptr_reg;

  logic        fifo_empty, fifo_full;
  logic        push_edge, push, pop, dnld_rise;
  logic [24:0] head_addr;
  logic [7:0]  head_data;
  logic [18:0] sp_off;
  logic [15:0] bg_off;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                      (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign push_edge  = wr_sync_reg && !wr_prev_reg && dnld_sync_reg;
  assign push       = push_edge && !fifo_full;
  assign pop        = (state_reg == S_IDLE) && !fifo_empty;
  assign dnld_rise  = dnld_sync_reg && !dnld_prev_reg;

  assign {head_addr, head_data} = fifo_mem[rd_ptr_reg[PW-1:0]];
  assign sp_off = 19'(head_addr - SP_BASE);
  assign bg_off = 16'(head_addr - BG_BASE);

  assign busy = !fifo_empty || (state_reg != S_IDLE);

  // Input stage: one register on every ioctl signal so address/data line up with the strobe edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_sync_reg   <= 1'b0;
      wr_prev_reg   <= 1'b0;
      dnld_sync_reg <= 1'b0;
      dnld_prev_reg <= 1'b0;
      addr_sync_reg <= '0;
      data_sync_reg <= '0;
    end else begin
      wr_sync_reg   <= ioctl_wr;
      wr_prev_reg   <= wr_sync_reg;
      dnld_sync_reg <= ioctl_download;
      dnld_prev_reg <= dnld_sync_reg;
      addr_sync_reg <= ioctl_addr;
      data_sync_reg <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push)
      fifo_mem[wr_ptr_reg[PW-1:0]] <= {addr_sync_reg, data_sync_reg};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_edge && fifo_full)
        overflow <= 1'b1;
    end
  end

  // Decode happens in the pop cycle so the request toggles three cycles after the strobe edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
      dl_addr   <= '0;
      dl_wr     <= 1'b0;
      dl_data   <= '0;
    end else begin
      dl_wr <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            if (head_addr < SP_BASE) begin
              port1_a   <= head_addr[23:1];
              port1_ds  <= {head_addr[0], ~head_addr[0]};
              port1_d   <= {head_data, head_data};
              port1_req <= ~port1_req;
              state_reg <= S_WAIT1;
            end else if (head_addr < BG_BASE) begin
              port2_a   <= {sp_off[18:17], sp_off[14:0], sp_off[16]};
              port2_ds  <= {sp_off[15], ~sp_off[15]};
              port2_d   <= {head_data, head_data};
              port2_req <= ~port2_req;
              state_reg <= S_WAIT2;
            end else if (head_addr < ROM_END) begin
              dl_addr   <= bg_off;
              dl_data   <= head_data;
              dl_wr     <= 1'b1;
              state_reg <= S_BG;
            end
          end
        end
        S_WAIT1: if (port1_ack == port1_req) state_reg <= S_IDLE;
        S_WAIT2: if (port2_ack == port2_req) state_reg <= S_IDLE;
        S_BG:    state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Load tracking and core reset stretch; core_reset drops exactly RST_HOLD cycles after rom_loaded.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      loading_reg  <= 1'b0;
      rom_loaded   <= 1'b0;
      core_reset   <= 1'b1;
      hold_cnt_reg <= RST_HOLD;
    end else begin
      if (dnld_rise) begin
        loading_reg <= 1'b1;
        rom_loaded  <= 1'b0;
      end else if (loading_reg && !dnld_sync_reg && !push_edge && fifo_empty &&
                   (state_reg == S_IDLE)) begin
        loading_reg <= 1'b0;
        rom_loaded  <= 1'b1;
      end

      if (!rom_loaded || dnld_sync_reg) begin
        hold_cnt_reg <= RST_HOLD;
        core_reset   <= 1'b1;
      end else if (hold_cnt_reg != 16'd0) begin
        hold_cnt_reg <= hold_cnt_reg - 16'd1;
        core_reset   <= (hold_cnt_reg != 16'd1);
      end else begin
        core_reset <= 1'b0;
      end
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (dnld_rise) begin
      checksum <= push ? {8'd0, data_sync_reg} : 16'd0;
    end else if (push) begin
      checksum <= checksum + {8'd0, data_sync_reg};
    end
  end
`endif

endmodule

// File: tb/tb_timber_rom_loader.sv
// Directed bench for timber_rom_loader: region routing, latency, overflow, load/reset sequencing.
module tb_timber_rom_loader;

  localparam logic [15:0] HOLD = 16'd40;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req, port2_ack;
  logic [17:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic [15:0] dl_addr;
  logic        dl_wr;
  logic [7:0]  dl_data;
  logic        busy, overflow, rom_loaded, core_reset;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ack1_delay = 4;
  int ack2_delay = 4;

  logic [22:0] q1_a[$];
  logic [1:0]  q1_ds[$];
  logic [15:0] q1_d[$];
  logic [17:0] q2_a[$];
  logic [1:0]  q2_ds[$];
  logic [15:0] q2_d[$];
  logic [15:0] qdl_addr[$];
  logic [7:0]  qdl_data[$];
  logic        last_req1, last_req2;

  timber_rom_loader #(.RST_HOLD(HOLD)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .dl_addr(dl_addr), .dl_wr(dl_wr), .dl_data(dl_data),
    .busy(busy), .overflow(overflow), .rom_loaded(rom_loaded),
`ifdef ROM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .core_reset(core_reset)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // SDRAM-side responder: echoes req onto ack after a programmable number of cycles.
  initial begin
    int cnt1, cnt2;
    cnt1 = 0; cnt2 = 0;
    port1_ack = 1'b0;
    port2_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #2;
      if (!reset_n) begin
        port1_ack = 1'b0; port2_ack = 1'b0; cnt1 = 0; cnt2 = 0;
      end else begin
        if (port1_req !== port1_ack) begin
          cnt1++;
          if (cnt1 >= ack1_delay) begin port1_ack = port1_req; cnt1 = 0; end
        end else cnt1 = 0;
        if (port2_req !== port2_ack) begin
          cnt2++;
          if (cnt2 >= ack2_delay) begin port2_ack = port2_req; cnt2 = 0; end
        end else cnt2 = 0;
      end
    end
  end

  // Transaction recorder: one entry per req toggle or dl_wr strobe.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      last_req1 = 1'b0;
      last_req2 = 1'b0;
    end else begin
      if (port1_req !== last_req1) begin
        q1_a.push_back(port1_a); q1_ds.push_back(port1_ds); q1_d.push_back(port1_d);
        last_req1 = port1_req;
      end
      if (port2_req !== last_req2) begin
        q2_a.push_back(port2_a); q2_ds.push_back(port2_ds); q2_d.push_back(port2_d);
        last_req2 = port2_req;
      end
      if (dl_wr === 1'b1) begin
        qdl_addr.push_back(dl_addr); qdl_data.push_back(dl_data);
      end
    end
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    @(posedge clk_sys); #1;
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    $display("tx  addr=%05h data=%02h", a, d);
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk_sys); #1;
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_loaded(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk_sys); #1;
      if (rom_loaded === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // Counts cycles from the rom_loaded rise (already observed) to core_reset falling.
  task automatic measure_hold(output int cycles);
    cycles = -1;
    for (int i = 1; i <= int'(HOLD) + 20; i++) begin
      @(posedge clk_sys); #1;
      if (core_reset === 1'b0) begin cycles = i; break; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    n_checks++; if (port1_req !== 1'b0) begin n_fail++; $display("FAIL reset_port1_req got=%b exp=0", port1_req); end
    n_checks++; if (port2_req !== 1'b0) begin n_fail++; $display("FAIL reset_port2_req got=%b exp=0", port2_req); end
    n_checks++; if (dl_wr !== 1'b0) begin n_fail++; $display("FAIL reset_dl_wr got=%b exp=0", dl_wr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_checks++; if (rom_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_rom_loaded got=%b exp=0", rom_loaded); end
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
    n_checks++; if (port1_a !== 23'd0 || dl_addr !== 16'd0) begin n_fail++; $display("FAIL reset_addr got=%h/%h exp=0/0", port1_a, dl_addr); end
    reset_n = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    n_checks++; if (rom_loaded !== 1'b0 || core_reset !== 1'b1) begin n_fail++; $display("FAIL reset_no_download got=%b/%b exp=0/1", rom_loaded, core_reset); end
  endtask

  task automatic test_p1;
    bit ok; int n1, n2; logic r0;
    ioctl_download = 1'b1;
    repeat (3) @(posedge clk_sys);
    n1 = q1_a.size(); n2 = q2_a.size(); r0 = port1_req; ack1_delay = 4;
    @(posedge clk_sys); #1;
    ioctl_addr = 25'h00005; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
    n_checks++; if (port1_req !== r0) begin n_fail++; $display("FAIL p1_early_req got=%b exp=%b", port1_req, r0); end
    @(posedge clk_sys); #1;
    n_checks++; if (port1_req !== ~r0) begin n_fail++; $display("FAIL p1_latency_req got=%b exp=%b", port1_req, ~r0); end
    n_checks++; if (port1_a !== 23'd2) begin n_fail++; $display("FAIL p1_a got=%h exp=2", port1_a); end
    n_checks++; if (port1_ds !== 2'b10) begin n_fail++; $display("FAIL p1_ds got=%b exp=10", port1_ds); end
    n_checks++; if (port1_d !== 16'hA5A5) begin n_fail++; $display("FAIL p1_d got=%h exp=a5a5", port1_d); end
    repeat (2) @(posedge clk_sys); #1;
    n_checks++; if (busy !== 1'b1 || port1_a !== 23'd2 || port1_d !== 16'hA5A5) begin n_fail++; $display("FAIL p1_hold busy=%b a=%h d=%h exp 1/2/a5a5", busy, port1_a, port1_d); end
    wait_idle(30, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL p1_busy_fall got=%b exp=1 (timeout)", ok); end
    n_checks++; if (q1_a.size() !== n1 + 1) begin n_fail++; $display("FAIL p1_toggles got=%0d exp=1", q1_a.size() - n1); end
    n_checks++; if (q2_a.size() !== n2) begin n_fail++; $display("FAIL p1_port2_quiet got=%0d exp=0", q2_a.size() - n2); end
  endtask

  task automatic test_p2;
    bit ok; int n1, n2;
    n1 = q1_a.size(); n2 = q2_a.size();
    send_byte(25'h19000, 8'h3C);
    wait_idle(30, ok);
    n_checks++; if (ok !== 1'b1 || q2_a.size() !== n2 + 1) begin n_fail++; $display("FAIL p2_first_count got=%0d exp=1 ok=%b", q2_a.size() - n2, ok); end
    else begin
      n_checks++; if (q2_a[n2] !== 18'h00000 || q2_ds[n2] !== 2'b10 || q2_d[n2] !== 16'h3C3C) begin n_fail++; $display("FAIL p2_first got=%h/%b/%h exp=00000/10/3c3c", q2_a[n2], q2_ds[n2], q2_d[n2]); end
    end
    send_byte(25'h2D003, 8'h5A);
    wait_idle(30, ok);
    n_checks++; if (ok !== 1'b1 || q2_a.size() !== n2 + 2) begin n_fail++; $display("FAIL p2_second_count got=%0d exp=2 ok=%b", q2_a.size() - n2, ok); end
    else begin
      n_checks++; if (q2_a[n2+1] !== 18'h08007 || q2_ds[n2+1] !== 2'b10 || q2_d[n2+1] !== 16'h5A5A) begin n_fail++; $display("FAIL p2_swizzle got=%h/%b/%h exp=08007/10/5a5a", q2_a[n2+1], q2_ds[n2+1], q2_d[n2+1]); end
    end
    n_checks++; if (q1_a.size() !== n1) begin n_fail++; $display("FAIL p2_port1_quiet got=%0d exp=0", q1_a.size() - n1); end
  endtask

  task automatic test_bg;
    bit ok; int n1, n2, nd;
    n1 = q1_a.size(); n2 = q2_a.size(); nd = qdl_addr.size();
    @(posedge clk_sys); #1;
    ioctl_addr = 25'h31010; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
    n_checks++; if (dl_wr !== 1'b0) begin n_fail++; $display("FAIL bg_early got=%b exp=0", dl_wr); end
    @(posedge clk_sys); #1;
    n_checks++; if (dl_wr !== 1'b1 || dl_addr !== 16'h0010 || dl_data !== 8'h77) begin n_fail++; $display("FAIL bg_write got=%b/%h/%h exp=1/0010/77", dl_wr, dl_addr, dl_data); end
    @(posedge clk_sys); #1;
    n_checks++; if (dl_wr !== 1'b0) begin n_fail++; $display("FAIL bg_one_cycle got=%b exp=0", dl_wr); end
    wait_idle(10, ok);
    n_checks++; if (ok !== 1'b1 || qdl_addr.size() !== nd + 1) begin n_fail++; $display("FAIL bg_count got=%0d exp=1 ok=%b", qdl_addr.size() - nd, ok); end
    n_checks++; if (q1_a.size() !== n1 || q2_a.size() !== n2) begin n_fail++; $display("FAIL bg_no_req got=%0d/%0d exp=0/0", q1_a.size() - n1, q2_a.size() - n2); end
  endtask

  task automatic test_overflow;
    bit ok; int n1; logic [24:0] ea; logic [7:0] ed;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_initial got=%b exp=0", overflow); end
    n1 = q1_a.size();
    ack1_delay = 50;
    for (int k = 0; k < 6; k++) send_byte(25'h100 + 25'(k), 8'h10 + 8'(k));
    repeat (2) @(posedge clk_sys); #1;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    wait_idle(600, ok);
    n_checks++; if (ok !== 1'b1 || q1_a.size() !== n1 + 5) begin n_fail++; $display("FAIL ovf_accepted got=%0d exp=5 ok=%b", q1_a.size() - n1, ok); end
    else begin
      for (int i = 0; i < 5; i++) begin
        ea = 25'h100 + 25'(i); ed = 8'h10 + 8'(i);
        n_checks++;
        if (q1_a[n1+i] !== ea[23:1] || q1_ds[n1+i] !== {ea[0], ~ea[0]} || q1_d[n1+i] !== {ed, ed}) begin
          n_fail++;
          $display("FAIL ovf_order[%0d] got=%h/%b/%h exp=%h/%b/%h", i, q1_a[n1+i], q1_ds[n1+i], q1_d[n1+i], ea[23:1], {ea[0], ~ea[0]}, {ed, ed});
        end
      end
    end
    ack1_delay = 4;
  endtask

  task automatic test_load_done;
    bit ok; int cyc;
    n_checks++; if (core_reset !== 1'b1 || rom_loaded !== 1'b0) begin n_fail++; $display("FAIL load_during got=%b/%b exp=1/0", core_reset, rom_loaded); end
    ioctl_download = 1'b0;
    wait_loaded(20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL load_rom_loaded got=%b exp=1 (timeout)", rom_loaded); end
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL load_reset_held got=%b exp=1", core_reset); end
    measure_hold(cyc);
    n_checks++; if (cyc !== int'(HOLD)) begin n_fail++; $display("FAIL load_hold_cycles got=%0d exp=%0d", cyc, HOLD); end
  endtask

  task automatic test_reload;
    bit ok; int n1, n2, nd, cyc;
    n1 = q1_a.size(); n2 = q2_a.size(); nd = qdl_addr.size();
    ioctl_download = 1'b1;
    repeat (3) @(posedge clk_sys); #1;
    n_checks++; if (rom_loaded !== 1'b0 || core_reset !== 1'b1) begin n_fail++; $display("FAIL reload_clear got=%b/%b exp=0/1", rom_loaded, core_reset); end
    send_byte(25'h00010, 8'h11);
    send_byte(25'h11002, 8'h22);
    send_byte(25'h31000, 8'h33);
    send_byte(25'h38FFF, 8'h44);
    for (int k = 0; k < 16; k++) send_byte(25'h39000 + 25'(k), 8'hE0 + 8'(k));
    wait_idle(60, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL reload_drain got=%b exp=1 (timeout)", ok); end
    n_checks++; if (q1_a.size() !== n1 + 1 || q2_a.size() !== n2 + 1 || qdl_addr.size() !== nd + 2) begin
      n_fail++; $display("FAIL reload_routing got=%0d/%0d/%0d exp=1/1/2", q1_a.size() - n1, q2_a.size() - n2, qdl_addr.size() - nd);
    end else begin
      n_checks++; if (qdl_addr[nd+1] !== 16'h7FFF || qdl_data[nd+1] !== 8'h44) begin n_fail++; $display("FAIL reload_bg_last got=%h/%h exp=7fff/44", qdl_addr[nd+1], qdl_data[nd+1]); end
    end
    ioctl_download = 1'b0;
    wait_loaded(20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL reload_loaded got=%b exp=1 (timeout)", rom_loaded); end
    measure_hold(cyc);
    n_checks++; if (cyc !== int'(HOLD)) begin n_fail++; $display("FAIL reload_hold_cycles got=%0d exp=%0d", cyc, HOLD); end
  endtask

`ifdef ROM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    bit ok;
    ioctl_download = 1'b1;
    repeat (3) @(posedge clk_sys);
    send_byte(25'h39000, 8'hFF);
    send_byte(25'h00020, 8'h02);
    wait_idle(30, ok);
    ioctl_download = 1'b0;
    wait_loaded(20, ok);
    n_checks++; if (ok !== 1'b1 || checksum !== 16'h0101) begin n_fail++; $display("FAIL checksum got=%h exp=0101 loaded=%b", checksum, ok); end
  endtask
`endif

  task automatic test_async_reset;
    bit ok;
    ioctl_download = 1'b1;
    repeat (3) @(posedge clk_sys);
    if (port1_req === 1'b1) begin
      send_byte(25'h00040, 8'h01);
      wait_idle(30, ok);
    end
    ack1_delay = 50;
    send_byte(25'h00042, 8'h02);
    repeat (3) @(posedge clk_sys); #1;
    n_checks++; if (port1_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL areset_pre got=%b/%b exp=1/1", port1_req, busy); end
    #3 reset_n = 1'b0;
    #1;
    n_checks++; if (port1_req !== 1'b0) begin n_fail++; $display("FAIL areset_req got=%b exp=0", port1_req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got=%b exp=0", busy); end
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL areset_core_reset got=%b exp=1", core_reset); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL areset_overflow got=%b exp=0", overflow); end
    ioctl_download = 1'b0;
    ack1_delay = 4;
    repeat (2) @(posedge clk_sys); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk_sys); #1;
    n_checks++; if (busy !== 1'b0 || port1_req !== 1'b0) begin n_fail++; $display("FAIL areset_after got=%b/%b exp=0/0", busy, port1_req); end
  endtask

  initial begin
    test_reset();
    test_p1();
    test_p2();
    test_bg();
    test_overflow();
    test_load_done();
    test_reload();
`ifdef ROM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
